victim_cache_assoc: RTL and testbench
=====================================

Name: victim_cache_assoc

Overview:
- Parametrised, fully associative victim cache with true-LRU replacement and a 4-stage pipeline: PRE, TL, TV, DM.
- Sits beside the L1 data cache. On read, it looks up a virtual index plus the late-arriving physical tag and returns one byte, or an N-byte word.
- On write, it accepts a block evicted from L1 and returns any block it must displace in turn.
- Generalises the fixed 64-byte / single-byte design to configurable depth, block size and output width, and adds flush, valid handshake and an explicit eviction output.

Parameters:
- ENTRIES, 8, number of fully associative entries; power of 2, 2..32.
- BLOCK_BYTES, 64, bytes per block; power of 2.
- TAG_W, 44, physical tag width.
- PO_W, 12, page offset width.
- OUT_BYTES, 1, bytes returned per read; power of 2, at most BLOCK_BYTES.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present this cycle.
- page_offset  in  PO_W  virtual index and byte offset. The low log2(BLOCK_BYTES) bits are the offset; the rest is the vindex.
- write_en  in  1  1 = insert data_in, 0 = read.
- data_in  in  8*BLOCK_BYTES  block to insert.
- flush  in  1  invalidate all entries.
- phys_tag_ret  in  TAG_W  physical tag; arrives one cycle after the request.
- tlb_miss  in  1  TLB miss; arrives one cycle after the request.
- out_valid  out  1  a read result is present.
- is_found  out  1  the read hit.
- byte_out  out  8*OUT_BYTES  selected bytes of the hit block, aligned down to an OUT_BYTES boundary.
- block_out  out  8*BLOCK_BYTES  hit block on a read; evicted block on a write.
- evict_valid  out  1  block_out holds a displaced valid block.

Behaviour:
- Reset:
  - Synchronous, active-high.
  - All entries become invalid.
  - LRU ages are set to entry index: entry ENTRIES-1 is LRU.
  - All pipeline valids clear.
  - All outputs are 0.
- Key: {phys_tag_ret, vindex}.
- PRE, at edge E0: registers req_valid, write_en, page_offset and data_in. No stall; one request is accepted per cycle.
- TL, during the cycle after E0:
  - phys_tag_ret and tlb_miss are sampled at E1.
  - Key is compared in parallel against all valid entries. At most one match is guaranteed by the insert rule.
- TL, read with tlb_miss=1: the operation is killed. The next-stage valid clears, no LRU update occurs, and out_valid stays 0.
- TL, read hit: the matching entry becomes MRU. The block and offset are passed to TV with found=1.
- TL, read miss: found=0 and block is 0. The read still reaches DM, giving out_valid=1 and is_found=0.
- TL, write: tlb_miss is ignored. Victim selection, in priority order:
  - the matching entry;
  - otherwise the lowest-index invalid entry;
  - otherwise the LRU entry.
- TL, write commit: data and key are written at E1. The entry becomes valid and MRU.
- TL, write eviction: evict_valid=1 only if a different valid key was displaced. block_out then carries the old block.
- TL, state visibility: a write at TL is visible to a read at TL in the next cycle. Back-to-back write then read of the same key hits without forwarding.
- LRU ages:
  - Each entry has a log2(ENTRIES)-bit age.
  - On touch of entry k, every age below age[k] increments and age[k] becomes 0.
  - The LRU entry is the one with age ENTRIES-1.
- TV: selects the OUT_BYTES-aligned chunk indexed by offset.
- DM: registers outputs at E3.
- Latency:
  - Read: outputs are valid for exactly one cycle after E3 (3 cycles after sampling).
  - Write: evict_valid and block_out follow the same 3-cycle latency, with out_valid=0.
- Idle cycles: out_valid, evict_valid and is_found are 0. byte_out and block_out hold their last value.
- flush:
  - Sampled at E0.
  - Invalidates all entries at that edge and resets LRU as on reset.
  - Kills ops in TL and TV; their results never appear.
  - A request sampled in the same cycle as flush proceeds normally against the empty cache.
- reset mid-operation: all in-flight ops are discarded.

Decomposition:
- Package vc_pkg: localparams OFF_W=log2(BLOCK_BYTES), IDX_W=PO_W-OFF_W, KEY_W=TAG_W+IDX_W, WAY_W=log2(ENTRIES).
- Package vc_pkg: typedef struct for the pipeline payload {valid, wr, found, offset, block}.
- Sub-module vc_lru_ages:
  - Inputs: touch, touch_idx.
  - Outputs: lru_idx.
  - Contains the age array and its reset.

Test Plan:
- Reset, then read of page_offset=0x040 with ptag=0x1 -> at E3 out_valid=1, is_found=0, byte_out=0, evict_valid=0.
- Write ptag=0xABC, po=0x080, block bytes[i]=i. Then read ptag=0xABC, po=0x085 the next cycle -> hit, byte_out=0x05, block_out=the written block.
- Read with tlb_miss=1 -> out_valid stays 0 at E3. Repeat the read with tlb_miss=1 on a write -> the write commits and a later read hits.
- Fill 8 distinct keys K0..K7, read K0, then write K8 -> evict_valid=1 with block_out=K1's block. Subsequent reads: K1 misses, K0 and K8 hit.
- Rewrite existing key K3 with new data -> evict_valid=0, no other entry lost, and a read returns the new data.
- Fill 3 keys, assert flush while a read of K0 is in TL -> that read produces no output. A subsequent read of K0 returns is_found=0.

Source files
------------

// File: rtl/vc_pkg.sv
// Shared configuration defaults and pipeline control payload for the victim cache.
package vc_pkg;

  localparam int DEF_ENTRIES     = 8;
  localparam int DEF_BLOCK_BYTES = 64;
  localparam int DEF_TAG_W       = 44;
  localparam int DEF_PO_W        = 12;
  localparam int DEF_OUT_BYTES   = 1;

  localparam int OFF_W = $clog2(DEF_BLOCK_BYTES);
  localparam int IDX_W = DEF_PO_W - OFF_W;
  localparam int KEY_W = DEF_TAG_W + IDX_W;
  localparam int WAY_W = $clog2(DEF_ENTRIES);

  // Width-independent half of the stage payload; offset and block travel beside it.
  typedef struct packed {
    logic vld;
    logic wr;
    logic found;
    logic evict;
  } pipe_ctl_t;

endpackage

// File: rtl/victim_cache_assoc_if.sv
// Request/response bundle between the L1 data cache and the victim cache.
interface victim_cache_assoc_if #(
  parameter int TAG_W       = vc_pkg::DEF_TAG_W,
  parameter int PO_W        = vc_pkg::DEF_PO_W,
  parameter int BLOCK_BYTES = vc_pkg::DEF_BLOCK_BYTES,
  parameter int OUT_BYTES   = vc_pkg::DEF_OUT_BYTES
);
  logic                     req_valid;
  logic [PO_W-1:0]          page_offset;
  logic                     write_en;
  logic [8*BLOCK_BYTES-1:0] data_in;
  logic                     flush;
  logic [TAG_W-1:0]         phys_tag_ret;
  logic                     tlb_miss;
  logic                     out_valid;
  logic                     is_found;
  logic [8*OUT_BYTES-1:0]   byte_out;
  logic [8*BLOCK_BYTES-1:0] block_out;
  logic                     evict_valid;

  modport master (
    output req_valid, page_offset, write_en, data_in, flush, phys_tag_ret, tlb_miss,
    input  out_valid, is_found, byte_out, block_out, evict_valid
  );

  modport slave (
    input  req_valid, page_offset, write_en, data_in, flush, phys_tag_ret, tlb_miss,
    output out_valid, is_found, byte_out, block_out, evict_valid
  );
endinterface

// File: rtl/vc_lru_ages.sv
// True-LRU age array: touched entry goes to age 0, younger entries age by one.
module vc_lru_ages #(
  parameter int ENTRIES = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       touch,
  input  logic [$clog2(ENTRIES)-1:0] touch_idx,
  output logic [$clog2(ENTRIES)-1:0] lru_idx
);
  localparam int WAY_W = $clog2(ENTRIES);

  logic [WAY_W-1:0] ages [ENTRIES];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < ENTRIES; i++) ages[i] <= WAY_W'(i);
    end else if (touch) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (WAY_W'(i) == touch_idx)
          ages[i] <= '0;
        else if (ages[i] < ages[touch_idx])
          ages[i] <= ages[i] + 1'b1;
      end
    end
  end

  always_comb begin
    lru_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ages[i] == WAY_W'(ENTRIES - 1)) lru_idx = WAY_W'(i);
    end
  end
endmodule

// File: rtl/victim_cache_assoc.sv
// Fully associative victim cache, four stages: PRE (capture), TL (lookup/commit), TV (chunk select), DM (outputs).
module victim_cache_assoc #(
  parameter int ENTRIES     = vc_pkg::DEF_ENTRIES,
  parameter int BLOCK_BYTES = vc_pkg::DEF_BLOCK_BYTES,
  parameter int TAG_W       = vc_pkg::DEF_TAG_W,
  parameter int PO_W        = vc_pkg::DEF_PO_W,
  parameter int OUT_BYTES   = vc_pkg::DEF_OUT_BYTES
) (
  input logic               clk,
  input logic               reset,
  victim_cache_assoc_if.slave bus
);
  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int IDX_W = PO_W - OFF_W;
  localparam int KEY_W = TAG_W + IDX_W;
  localparam int WAY_W = $clog2(ENTRIES);
  localparam int BLK_W = 8 * BLOCK_BYTES;
  localparam int OUT_W = 8 * OUT_BYTES;

  logic             valid_q [ENTRIES];
  logic [KEY_W-1:0] key_q   [ENTRIES];
  logic [BLK_W-1:0] data_q  [ENTRIES];

  logic             vld_p0;
  logic             wr_p0;
  logic [PO_W-1:0]  po_p0;
  logic [BLK_W-1:0] din_p0;

  vc_pkg::pipe_ctl_t ctl_p1, ctl_p2;
  logic [OFF_W-1:0]  off_p1;
  logic [BLK_W-1:0]  block_p1, block_p2;
  logic [OUT_W-1:0]  chunk_p2;

  logic [KEY_W-1:0] key_tl;
  logic             hit, inv_any, evict, rd_ok, wr_ok, touch;
  logic [WAY_W-1:0] hit_idx, inv_idx, lru_idx, victim_idx, touch_idx;
  logic [BLK_W-1:0] block_tl;
  logic [OFF_W-1:0] aligned_p1;
  logic [OFF_W+2:0] bit_sel_p1;
  logic [OUT_W-1:0] chunk_p1;

  // PRE: capture the request; the physical tag is still in flight
  always_ff @(posedge clk) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= bus.req_valid;
    wr_p0  <= bus.write_en;
    po_p0  <= bus.page_offset;
    din_p0 <= bus.data_in;
  end

  assign key_tl = {bus.phys_tag_ret, po_p0[PO_W-1:OFF_W]};

  // Descending scan leaves the lowest-index invalid slot in inv_idx.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    inv_any = 1'b0;
    inv_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && key_q[i] == key_tl) begin
        hit     = 1'b1;
        hit_idx = WAY_W'(i);
      end
      if (!valid_q[i]) begin
        inv_any = 1'b1;
        inv_idx = WAY_W'(i);
      end
    end
  end

  assign victim_idx = hit ? hit_idx : (inv_any ? inv_idx : lru_idx);
  assign rd_ok      = vld_p0 && !wr_p0 && !bus.tlb_miss && !bus.flush;
  assign wr_ok      = vld_p0 && wr_p0 && !bus.flush;
  assign evict      = wr_ok && !hit && !inv_any;
  assign touch      = wr_ok || (rd_ok && hit);
  assign touch_idx  = wr_p0 ? victim_idx : hit_idx;

  always_comb begin
    block_tl = '0;
    if (wr_p0)    block_tl = data_q[victim_idx];
    else if (hit) block_tl = data_q[hit_idx];
  end

  vc_lru_ages #(.ENTRIES(ENTRIES)) u_lru (
    .clk      (clk),
    .reset    (reset),
    .clear    (bus.flush),
    .touch    (touch),
    .touch_idx(touch_idx),
    .lru_idx  (lru_idx)
  );

  // TL: commit writes into the entry array
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (wr_ok) begin
      valid_q[victim_idx] <= 1'b1;
    end
    if (wr_ok) begin
      key_q[victim_idx]  <= key_tl;
      data_q[victim_idx] <= din_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ctl_p1.vld <= 1'b0;
    else       ctl_p1.vld <= rd_ok || wr_ok;
    ctl_p1.wr    <= wr_p0;
    ctl_p1.found <= hit && !wr_p0;
    ctl_p1.evict <= evict;
    off_p1       <= po_p0[OFF_W-1:0];
    block_p1     <= block_tl;
  end

  // TV: pick the OUT_BYTES-aligned chunk addressed by the offset
  assign aligned_p1 = off_p1 & ~OFF_W'(OUT_BYTES - 1);
  assign bit_sel_p1 = {aligned_p1, 3'b000};
  assign chunk_p1   = block_p1[bit_sel_p1 +: OUT_W];

  always_ff @(posedge clk) begin
    if (reset || bus.flush) ctl_p2.vld <= 1'b0;
    else                    ctl_p2.vld <= ctl_p1.vld;
    ctl_p2.wr    <= ctl_p1.wr;
    ctl_p2.found <= ctl_p1.found;
    ctl_p2.evict <= ctl_p1.evict;
    chunk_p2     <= chunk_p1;
    block_p2     <= block_p1;
  end

  // DM: registered outputs; data outputs hold when nothing new arrives
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid   <= 1'b0;
      bus.is_found    <= 1'b0;
      bus.evict_valid <= 1'b0;
      bus.byte_out    <= '0;
      bus.block_out   <= '0;
    end else begin
      bus.out_valid   <= ctl_p2.vld && !ctl_p2.wr;
      bus.is_found    <= ctl_p2.vld && !ctl_p2.wr && ctl_p2.found;
      bus.evict_valid <= ctl_p2.vld && ctl_p2.wr && ctl_p2.evict;
      if (ctl_p2.vld && !ctl_p2.wr)
        bus.byte_out <= chunk_p2;
      if (ctl_p2.vld && (!ctl_p2.wr || ctl_p2.evict))
        bus.block_out <= block_p2;
    end
  end
endmodule

// File: tb/tb_victim_cache_assoc.sv
// Directed bench for victim_cache_assoc at default parameters.
module tb_victim_cache_assoc;
  localparam int BB = 64;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  victim_cache_assoc_if bus ();

  victim_cache_assoc dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [8*BB-1:0] mk_block(input int base);
    logic [8*BB-1:0] b;
    for (int i = 0; i < BB; i++) b[i*8 +: 8] = 8'(base + i);
    return b;
  endfunction

  function automatic logic [43:0] ktag(input int n);
    return 44'(32'h100 + n);
  endfunction

  function automatic logic [11:0] kpo(input int n, input int off);
    return 12'((n << 6) | off);
  endfunction

  task automatic step(input logic rv, input logic wr, input logic [11:0] po,
                      input logic [8*BB-1:0] d, input logic [43:0] tag,
                      input logic tlb, input logic fl);
    bus.req_valid    = rv;
    bus.write_en     = wr;
    bus.page_offset  = po;
    bus.data_in      = d;
    bus.phys_tag_ret = tag;
    bus.tlb_miss     = tlb;
    bus.flush        = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [8*BB-1:0] obs, input logic [8*BB-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Non-overlapped op: request, tag cycle, then wait until DM outputs are visible.
  task automatic op(input logic wr, input logic [11:0] po, input logic [8*BB-1:0] d,
                    input logic [43:0] tag, input logic tlb);
    step(1'b1, wr, po, d, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, '0, tag, tlb, 1'b0);
    idle();
    idle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
  endtask

  task automatic chk_rd(input string name, input logic found, input logic [7:0] b);
    chk({name, ".out_valid"}, bus.out_valid, 1'b1);
    chk({name, ".is_found"}, bus.is_found, found);
    chk({name, ".byte_out"}, bus.byte_out, b);
  endtask

  initial begin
    reset = 1'b1;
    do_reset();
    chk("rst.out_valid", bus.out_valid, 1'b0);
    chk("rst.is_found", bus.is_found, 1'b0);
    chk("rst.evict_valid", bus.evict_valid, 1'b0);
    chk("rst.byte_out", bus.byte_out, '0);
    chk("rst.block_out", bus.block_out, '0);

    // Cold read misses
    op(1'b0, 12'h040, '0, 44'h1, 1'b0);
    chk_rd("cold", 1'b0, 8'h00);
    chk("cold.evict_valid", bus.evict_valid, 1'b0);
    chk("cold.block_out", bus.block_out, '0);
    idle();
    chk("cold.idle_out_valid", bus.out_valid, 1'b0);

    // Write then read of the same key on the next cycle
    step(1'b1, 1'b1, 12'h080, mk_block(0), '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 12'h085, '0, 44'hABC, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 44'hABC, 1'b0, 1'b0);
    idle();
    chk("b2b.wr_out_valid", bus.out_valid, 1'b0);
    chk("b2b.wr_evict", bus.evict_valid, 1'b0);
    idle();
    chk_rd("b2b.rd", 1'b1, 8'h05);
    chk("b2b.block_out", bus.block_out, mk_block(0));
    idle();
    chk("b2b.idle_out_valid", bus.out_valid, 1'b0);
    chk("b2b.idle_found", bus.is_found, 1'b0);
    chk("b2b.hold_block", bus.block_out, mk_block(0));
    chk("b2b.hold_byte", bus.byte_out, 8'h05);

    // TLB miss kills reads but not writes
    op(1'b0, 12'h085, '0, 44'hABC, 1'b1);
    chk("tlb.rd_out_valid", bus.out_valid, 1'b0);
    op(1'b1, 12'h0C0, mk_block(8'h40), 44'h222, 1'b1);
    chk("tlb.wr_evict", bus.evict_valid, 1'b0);
    op(1'b0, 12'h0C3, '0, 44'h222, 1'b0);
    chk_rd("tlb.rd_after_wr", 1'b1, 8'h43);

    // Fill, make K0 MRU, then K8 displaces K1
    do_reset();
    for (int n = 0; n < 8; n++) begin
      op(1'b1, kpo(n, 0), mk_block(n * 16), ktag(n), 1'b0);
      chk("fill.evict", bus.evict_valid, 1'b0);
    end
    op(1'b0, kpo(0, 3), '0, ktag(0), 1'b0);
    chk_rd("lru.rd_k0", 1'b1, 8'h03);
    op(1'b1, kpo(8, 0), mk_block(8'h80), ktag(8), 1'b0);
    chk("lru.k8_evict", bus.evict_valid, 1'b1);
    chk("lru.k8_block", bus.block_out, mk_block(8'h10));
    chk("lru.k8_out_valid", bus.out_valid, 1'b0);
    op(1'b0, kpo(1, 3), '0, ktag(1), 1'b0);
    chk_rd("lru.rd_k1", 1'b0, 8'h00);
    op(1'b0, kpo(0, 3), '0, ktag(0), 1'b0);
    chk_rd("lru.rd_k0b", 1'b1, 8'h03);
    op(1'b0, kpo(8, 3), '0, ktag(8), 1'b0);
    chk_rd("lru.rd_k8", 1'b1, 8'h83);

    // Rewrite of an existing key replaces in place
    op(1'b1, kpo(3, 0), mk_block(8'hA0), ktag(3), 1'b0);
    chk("rew.evict", bus.evict_valid, 1'b0);
    op(1'b0, kpo(3, 2), '0, ktag(3), 1'b0);
    chk_rd("rew.rd_k3", 1'b1, 8'hA2);
    chk("rew.block_k3", bus.block_out, mk_block(8'hA0));
    op(1'b0, kpo(2, 3), '0, ktag(2), 1'b0);
    chk_rd("rew.rd_k2", 1'b1, 8'h23);
    op(1'b0, kpo(7, 3), '0, ktag(7), 1'b0);
    chk_rd("rew.rd_k7", 1'b1, 8'h73);
    op(1'b0, kpo(8, 3), '0, ktag(8), 1'b0);
    chk_rd("rew.rd_k8", 1'b1, 8'h83);

    // Flush while a read is in TL; a write sampled with flush still lands
    do_reset();
    for (int n = 0; n < 3; n++) op(1'b1, kpo(n, 0), mk_block(n * 16), ktag(n), 1'b0);
    step(1'b1, 1'b0, kpo(0, 3), '0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, kpo(5, 0), mk_block(8'h50), ktag(0), 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, '0, ktag(5), 1'b0, 1'b0);
    idle();
    chk("flush.killed_rd", bus.out_valid, 1'b0);
    idle();
    chk("flush.wr_evict", bus.evict_valid, 1'b0);
    chk("flush.wr_out_valid", bus.out_valid, 1'b0);
    op(1'b0, kpo(0, 3), '0, ktag(0), 1'b0);
    chk_rd("flush.rd_k0", 1'b0, 8'h00);
    op(1'b0, kpo(5, 3), '0, ktag(5), 1'b0);
    chk_rd("flush.rd_k5", 1'b1, 8'h53);

    // Reset discards an in-flight read
    step(1'b1, 1'b0, kpo(5, 3), '0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b0, 1'b0, '0, '0, ktag(5), 1'b0, 1'b0);
    reset = 1'b0;
    idle();
    idle();
    chk("rstmid.out_valid", bus.out_valid, 1'b0);
    chk("rstmid.block_out", bus.block_out, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
